rps_match_scorer: RTL

Parametrised successor to the two-player rock-paper-scissors round counter. It judges each round from both players' guesses and keeps a per-player score and a round count. It ends the match on first-to-WIN_TARGET or after MAX_ROUNDS, then reports the match winner or a match draw. It sits between the guess-capture logic and the score display/LED driver.

---
 rtl/rps_match_scorer_if.sv | 38 +++
 rtl/rps_match_scorer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rps_match_scorer_if.sv
// Bundles the control and result signals between the guess-capture logic
// (master) and the rock-paper-scissors match scorer (slave).
//
// Handshake: start and round_valid are single-cycle valid pulses with no
// ready. The scorer takes whatever is presented on the cycle a pulse is
// high. p0_guess/p1_guess only matter while round_valid=1. If start and
// round_valid are both high, start takes priority and the round is dropped.
interface rps_match_scorer_if #(
    parameter int SCORE_W = 4,
    parameter int ROUND_W = 4
);
    logic               start;
    logic               round_valid;
    logic [1:0]         p0_guess;
    logic [1:0]         p1_guess;
    logic               win;
    logic               draw;
    logic               player;
    logic [SCORE_W-1:0] count0;
    logic [SCORE_W-1:0] count1;
    logic [ROUND_W-1:0] rounds;
    logic               busy;
    logic               match_done;
    logic               match_winner;
    logic               match_draw;

    modport master (
        output start, round_valid, p0_guess, p1_guess,
        input  win, draw, player, count0, count1, rounds,
        input  busy, match_done, match_winner, match_draw
    );

    modport slave (
        input  start, round_valid, p0_guess, p1_guess,
        output win, draw, player, count0, count1, rounds,
        output busy, match_done, match_winner, match_draw
    );
endinterface

// File: rtl/rps_match_scorer.sv
// Rock-paper-scissors match scorer: judges each round, keeps per-player
// scores and a round count, and closes the match on first-to-WIN_TARGET or
// after MAX_ROUNDS judged rounds. Guess encoding: 0=rock, 1=paper,
// 2=scissors, 3=no-show.
module rps_match_scorer #(
    parameter int SCORE_W    = 4,
    parameter int ROUND_W    = 4,
    parameter int WIN_TARGET = 3,
    parameter int MAX_ROUNDS = 9
) (
    input  logic               clk,
    input  logic               rst,
    rps_match_scorer_if.slave  bus,
    output logic [1:0]         fsm_state
);

    localparam logic [SCORE_W-1:0] TARGET_SCORE = SCORE_W'(WIN_TARGET);
    localparam logic [ROUND_W-1:0] LAST_ROUND   = ROUND_W'(MAX_ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               win_q;
    logic               draw_q;
    logic               player_q;
    logic [SCORE_W-1:0] count0_q;
    logic [SCORE_W-1:0] count1_q;
    logic [ROUND_W-1:0] rounds_q;
    logic               busy_q;
    logic               match_done_q;
    logic               match_winner_q;
    logic               match_draw_q;

    logic               p0_wins;
    logic               p1_wins;
    logic               round_draw;
    logic [SCORE_W-1:0] next_count0;
    logic [SCORE_W-1:0] next_count1;
    logic [ROUND_W-1:0] next_rounds;
    logic               hit_target;
    logic               hit_limit;

    // Judge the presented guesses; forfeits take precedence over the
    // rock-paper-scissors cycle, and a double no-show is a draw.
    always_comb begin
        p0_wins    = 1'b0;
        p1_wins    = 1'b0;
        round_draw = 1'b0;
        if (bus.p0_guess == 2'd3 && bus.p1_guess == 2'd3) begin
            round_draw = 1'b1;
        end else if (bus.p0_guess == 2'd3) begin
            p1_wins = 1'b1;
        end else if (bus.p1_guess == 2'd3) begin
            p0_wins = 1'b1;
        end else if (bus.p0_guess == bus.p1_guess) begin
            round_draw = 1'b1;
        end else if ((bus.p0_guess == 2'd1 && bus.p1_guess == 2'd0) ||
                     (bus.p0_guess == 2'd2 && bus.p1_guess == 2'd1) ||
                     (bus.p0_guess == 2'd0 && bus.p1_guess == 2'd2)) begin
            p0_wins = 1'b1;
        end else begin
            p1_wins = 1'b1;
        end
    end

    // Post-round counter values; match end is judged on these so the
    // closing round and match_done land on the same edge.
    always_comb begin
        next_count0 = count0_q + SCORE_W'(p0_wins);
        next_count1 = count1_q + SCORE_W'(p1_wins);
        next_rounds = rounds_q + ROUND_W'(1);
        hit_target  = (p0_wins && next_count0 == TARGET_SCORE) ||
                      (p1_wins && next_count1 == TARGET_SCORE);
        hit_limit   = (next_rounds == LAST_ROUND);
    end

    // Match FSM with all outputs registered; start overrides any round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            win_q          <= 1'b0;
            draw_q         <= 1'b0;
            player_q       <= 1'b0;
            count0_q       <= '0;
            count1_q       <= '0;
            rounds_q       <= '0;
            busy_q         <= 1'b0;
            match_done_q   <= 1'b0;
            match_winner_q <= 1'b0;
            match_draw_q   <= 1'b0;
        end else begin
            win_q  <= 1'b0;
            draw_q <= 1'b0;
            if (bus.start) begin
                state          <= PLAY;
                player_q       <= 1'b0;
                count0_q       <= '0;
                count1_q       <= '0;
                rounds_q       <= '0;
                busy_q         <= 1'b1;
                match_done_q   <= 1'b0;
                match_winner_q <= 1'b0;
                match_draw_q   <= 1'b0;
            end else begin
                case (state)
                    PLAY: begin
                        if (bus.round_valid) begin
                            win_q    <= ~round_draw;
                            draw_q   <= round_draw;
                            count0_q <= next_count0;
                            count1_q <= next_count1;
                            rounds_q <= next_rounds;
                            if (!round_draw) begin
                                player_q <= p1_wins;
                            end
                            if (hit_target) begin
                                state          <= DONE;
                                busy_q         <= 1'b0;
                                match_done_q   <= 1'b1;
                                match_winner_q <= p1_wins;
                            end else if (hit_limit) begin
                                state          <= DONE;
                                busy_q         <= 1'b0;
                                match_done_q   <= 1'b1;
                                match_winner_q <= (next_count1 > next_count0);
                                match_draw_q   <= (next_count1 == next_count0);
                            end
                        end
                    end
                    default: begin
                        // IDLE and DONE hold everything until start.
                    end
                endcase
            end
        end
    end

    assign bus.win          = win_q;
    assign bus.draw         = draw_q;
    assign bus.player       = player_q;
    assign bus.count0       = count0_q;
    assign bus.count1       = count1_q;
    assign bus.rounds       = rounds_q;
    assign bus.busy         = busy_q;
    assign bus.match_done   = match_done_q;
    assign bus.match_winner = match_winner_q;
    assign bus.match_draw   = match_draw_q;
    assign fsm_state        = state;

endmodule
